stream_rr_arbiter: RTL and testbench

- Shares one valid/ready stream consumer (a getter-side sink) between PORTS independent producers.
- Selects among requesters round-robin, with an optional burst lock of up to BURST consecutive beats per winner.
- Forwards the winning beat through a single output register, tagged with its source port index.
- Sits between multiple bulk producers and one downstream getter in the testbench/datapath stream fabric.

---
 rtl/stream_arb_pkg.sv | 23 ++
 rtl/rr_priority_picker.sv | 44 ++++
 rtl/stream_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// ----------------------------------------------------------------------------
// stream_arb_pkg
// Shared helpers for the round-robin stream arbiter.
//   IDX_W(ports)      : bits needed to hold a port index (at least 1).
//   CNT_W(burst)      : bits needed to count 0..burst beats.
//   next_idx(i,ports) : modulo increment with an explicit wrap from ports-1 to 0,
//                       so non-power-of-two port counts rotate correctly.
// ----------------------------------------------------------------------------
package stream_arb_pkg;

    function automatic int IDX_W(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    function automatic int CNT_W(input int burst);
        return $clog2(burst + 1);
    endfunction

    function automatic int next_idx(input int idx, input int ports);
        return (idx >= ports - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ----------------------------------------------------------------------------
// rr_priority_picker
// Combinational rotating-priority search: returns the first requester found
// when scanning i_start, i_start+1, ... modulo PORTS.
// Ports:
//   i_req       [PORTS] request vector
//   i_start     [IW]    index searched first
//   o_grant     [PORTS] one-hot grant (all-zero when nothing requests)
//   o_grant_idx [IW]    index of the granted requester (0 when none)
//   o_any       [1]     at least one requester was found
// ----------------------------------------------------------------------------
module rr_priority_picker
    import stream_arb_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IW    = IDX_W(PORTS)
) (
    input  logic [PORTS-1:0] i_req,
    input  logic [IW-1:0]    i_start,
    output logic [PORTS-1:0] o_grant,
    output logic [IW-1:0]    o_grant_idx,
    output logic             o_any
);

    always_comb begin
        logic [IW-1:0] w_k;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_k         = i_start;
        // Unrolled scan; the first hit wins, later hits are ignored.
        for (int i = 0; i < PORTS; i++) begin
            if (!o_any && i_req[w_k]) begin
                o_any       = 1'b1;
                o_grant_idx = w_k;
            end
            w_k = IW'(next_idx(int'(w_k), PORTS));
        end
        if (o_any) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// ----------------------------------------------------------------------------
// stream_rr_arbiter
// Shares one valid/ready consumer between PORTS producers. Winners are chosen
// round-robin; a winner may keep the grant for up to BURST consecutive beats
// while it stays valid. The winning beat is held in a single output register
// together with its source port index.
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_value   [PORTS*BITS] packed beats, port g at [g*BITS +: BITS]
//   in_valid   [PORTS]      per-port valid
//   in_ready   [PORTS]      per-port accept (one-hot or zero)
//   out_value  [BITS]       registered beat
//   out_valid               registered valid
//   out_ready               downstream accept
//   out_port   [clog2]      source port of out_value
// ----------------------------------------------------------------------------
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int PORTS = 4,
    parameter int BURST = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [PORTS*BITS-1:0]    in_value,
    input  logic [PORTS-1:0]         in_valid,
    output logic [PORTS-1:0]         in_ready,
    output logic [BITS-1:0]          out_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(PORTS)-1:0] out_port
);

    localparam int            IW      = IDX_W(PORTS);
    localparam int            CW      = CNT_W(BURST);
    localparam logic [CW-1:0] BURST_C = CW'(BURST);

    // Arbitration state
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [CW-1:0]    r_cnt;

    // Output register stage
    logic [BITS-1:0]  r_data_p1;
    logic             r_vld_p1;
    logic [IW-1:0]    r_port_p1;

    logic             w_ld;
    logic             w_locked;
    logic [PORTS-1:0] w_pick_grant;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic [PORTS-1:0] w_owner_onehot;
    logic [PORTS-1:0] w_grant_onehot;
    logic [IW-1:0]    w_gnt_idx;
    logic             w_any;
    logic [BITS-1:0]  w_lane [PORTS];
    logic [BITS-1:0]  w_beat;
    logic [CW-1:0]    w_cnt_base;
    logic [CW-1:0]    w_cnt_n;

    rr_priority_picker #(
        .PORTS (PORTS),
        .IW    (IW)
    ) u_picker (
        .i_req       (in_valid),
        .i_start     (r_ptr),
        .o_grant     (w_pick_grant),
        .o_grant_idx (w_pick_idx),
        .o_any       (w_pick_any)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign w_ld     = !r_vld_p1 || out_ready;
    // A burst only continues while its owner keeps presenting beats.
    assign w_locked = (r_cnt != '0) && in_valid[r_owner];

    always_comb begin
        w_owner_onehot          = '0;
        w_owner_onehot[r_owner] = 1'b1;
    end

    assign w_grant_onehot = w_locked ? w_owner_onehot : w_pick_grant;
    assign w_gnt_idx      = w_locked ? r_owner : w_pick_idx;
    assign w_any          = w_locked || w_pick_any;

    // in_ready is forced low during reset so no producer sees a phantom accept.
    assign in_ready = (reset_n && w_ld) ? w_grant_onehot : '0;

    always_comb begin
        for (int g = 0; g < PORTS; g++) begin
            w_lane[g] = in_value[g*BITS +: BITS];
        end
    end

    assign w_beat     = w_lane[w_gnt_idx];
    assign w_cnt_base = w_locked ? r_cnt : '0;
    assign w_cnt_n    = w_cnt_base + CW'(1);

    // ---- stage p0 -> p1: grant capture into the output register ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_port_p1 <= '0;
        end else if (w_ld) begin
            r_vld_p1 <= w_any;
            if (w_any) begin
                r_data_p1 <= w_beat;
                r_port_p1 <= w_gnt_idx;
                r_ptr     <= IW'(next_idx(int'(w_gnt_idx), PORTS));
                // A full burst releases the lock; otherwise this port owns the next beat.
                if (w_cnt_n == BURST_C) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt   <= w_cnt_n;
                    r_owner <= w_gnt_idx;
                end
            end
        end
    end

    assign out_value = r_data_p1;
    assign out_valid = r_vld_p1;
    assign out_port  = r_port_p1;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_stream_rr_arbiter
// Three arbiter instances (BURST = 1, 3, 4) on a shared clock and reset.
// Directed producers feed one instance at a time; expected beats are pushed
// into a scoreboard queue and a negedge monitor pops and compares each beat
// the DUTs hand downstream.
// ----------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    typedef struct packed {
        logic [1:0] inst;
        logic [1:0] port;
        logic [7:0] val;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] iv   [3];
    logic [3:0]  ivld [3];
    logic [2:0]  ordy;
    logic [11:0] irdy;
    logic [23:0] ov;
    logic [2:0]  ovld;
    logic [5:0]  op;
    int          rem  [3][4];
    exp_t        sbq  [$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    int t4_port [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int t4_val  [13] = '{'h00, 'h01, 'h02, 'h10, 'h11, 'h12,
                         'h20, 'h21, 'h22, 'h30, 'h31, 'h32, 'h03};

    always #5 clk = ~clk;

    stream_rr_arbiter #(.BITS(8), .PORTS(4), .BURST(1)) u_b1 (
        .clock(clk), .reset_n(rst_n), .in_value(iv[0]), .in_valid(ivld[0]),
        .in_ready(irdy[3:0]), .out_value(ov[7:0]), .out_valid(ovld[0]),
        .out_ready(ordy[0]), .out_port(op[1:0]));

    stream_rr_arbiter #(.BITS(8), .PORTS(4), .BURST(3)) u_b3 (
        .clock(clk), .reset_n(rst_n), .in_value(iv[1]), .in_valid(ivld[1]),
        .in_ready(irdy[7:4]), .out_value(ov[15:8]), .out_valid(ovld[1]),
        .out_ready(ordy[1]), .out_port(op[3:2]));

    stream_rr_arbiter #(.BITS(8), .PORTS(4), .BURST(4)) u_b4 (
        .clock(clk), .reset_n(rst_n), .in_value(iv[2]), .in_valid(ivld[2]),
        .in_ready(irdy[11:8]), .out_value(ov[23:16]), .out_valid(ovld[2]),
        .out_ready(ordy[2]), .out_port(op[5:4]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int m, input int g, input int v);
        exp_t e;
        e.inst = 2'(m);
        e.port = 2'(g);
        e.val  = 8'(v);
        sbq.push_back(e);
    endtask

    task automatic load(input int m, input int g, input int n, input int v0);
        rem[m][g]          = n;
        iv[m][g*8 +: 8]    = 8'(v0);
        ivld[m][g]         = (n > 0);
    endtask

    // One clock of producer activity on instance m; returns in_ready seen before the edge.
    task automatic step(input int m, output logic [3:0] rdy);
        logic [3:0] tk;
        @(negedge clk);
        rdy = irdy[m*4 +: 4];
        tk  = rdy & ivld[m];
        check("ready_without_valid", 32'(rdy & ~ivld[m]), 32'd0);
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            if (tk[g]) begin
                rem[m][g]--;
                iv[m][g*8 +: 8] = iv[m][g*8 +: 8] + 8'd1;
                if (rem[m][g] == 0) ivld[m][g] = 1'b0;
            end
        end
    endtask

    // Scoreboard monitor: every beat accepted downstream must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 3; m++) begin
                if (ovld[m] && ordy[m]) begin
                    if (sbq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: inst %0d port %0d value %0h, required no beat",
                                 m, op[m*2 +: 2], ov[m*8 +: 8]);
                    end else begin
                        mon_e = sbq.pop_front();
                        check("sb_inst",  32'(m),           32'(mon_e.inst));
                        check("sb_port",  32'(op[m*2 +: 2]), 32'(mon_e.port));
                        check("sb_value", 32'(ov[m*8 +: 8]), 32'(mon_e.val));
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] tk;
        for (int m = 0; m < 3; m++) begin
            iv[m]   = '0;
            ivld[m] = '0;
            for (int g = 0; g < 4; g++) rem[m][g] = 0;
        end
        ordy  = 3'b111;
        rst_n = 1'b0;

        // Reset with all ports valid, then plain round-robin (BURST=1)
        load(0, 0, 2, 'hA0);
        load(0, 1, 1, 'hB0);
        load(0, 2, 1, 'hC0);
        load(0, 3, 1, 'hD0);
        repeat (3) begin
            @(negedge clk);
            check("reset_in_ready",  32'(irdy[3:0]), 32'd0);
            check("reset_out_valid", 32'(ovld[0]),   32'd0);
        end
        check("reset_out_value", 32'(ov[7:0]), 32'd0);
        check("reset_out_port",  32'(op[1:0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0, 0, 'hA0); push(0, 1, 'hB0); push(0, 2, 'hC0);
        push(0, 3, 'hD0); push(0, 0, 'hA1);
        for (int k = 0; k < 5; k++) begin
            step(0, tk);
            check("rr_grant", 32'(tk), 32'(4'b0001 << (k % 4)));
        end
        step(0, tk);
        step(0, tk);

        // Single requester: back-to-back beats, one-cycle latency
        for (int k = 0; k < 4; k++) push(0, 2, 'h10 + k);
        load(0, 2, 4, 'h10);
        for (int k = 0; k < 4; k++) begin
            step(0, tk);
            check("single_grant",     32'(tk),      32'b0100);
            check("single_out_valid", 32'(ovld[0]), 32'd1);
        end
        step(0, tk);
        check("single_idle_out_valid", 32'(ovld[0]), 32'd0);

        // Backpressure: output held, no accepts, order preserved on release
        ordy[0] = 1'b0;
        load(0, 0, 1, 'h50);
        load(0, 1, 1, 'h51);
        push(0, 0, 'h50);
        push(0, 1, 'h51);
        step(0, tk);
        check("bp_first_grant", 32'(tk), 32'b0001);
        repeat (5) begin
            step(0, tk);
            check("bp_in_ready",   32'(tk),      32'd0);
            check("bp_hold_value", 32'(ov[7:0]), 32'h50);
            check("bp_hold_valid", 32'(ovld[0]), 32'd1);
        end
        ordy[0] = 1'b1;
        step(0, tk);
        check("bp_release_grant", 32'(tk), 32'b0010);
        step(0, tk);
        check("bp_after_grant", 32'(tk), 32'd0);
        step(0, tk);

        // Burst lock (BURST=3), all ports valid
        for (int k = 0; k < 13; k++) push(1, t4_port[k], t4_val[k]);
        load(1, 0, 4, 'h00);
        load(1, 1, 3, 'h10);
        load(1, 2, 3, 'h20);
        load(1, 3, 3, 'h30);
        for (int k = 0; k < 13; k++) begin
            step(1, tk);
            check("burst_grant", 32'(tk), 32'd1 << t4_port[k]);
        end
        step(1, tk);
        step(1, tk);

        // Lock break: port 1 leaves after one beat, port 3 takes a fresh burst
        push(1, 1, 'h61); push(1, 3, 'h70); push(1, 3, 'h71);
        push(1, 3, 'h72); push(1, 0, 'h50); push(1, 3, 'h73);
        load(1, 1, 1, 'h61);
        load(1, 3, 4, 'h70);
        step(1, tk);
        check("break_first", 32'(tk), 32'b0010);
        load(1, 0, 1, 'h50);
        step(1, tk);
        check("break_new_winner", 32'(tk), 32'b1000);
        step(1, tk);
        check("break_locked_1", 32'(tk), 32'b1000);
        step(1, tk);
        check("break_locked_2", 32'(tk), 32'b1000);
        step(1, tk);
        check("break_rotate", 32'(tk), 32'b0001);
        step(1, tk);
        check("break_tail", 32'(tk), 32'b1000);
        step(1, tk);
        step(1, tk);

        // Reset mid-burst (BURST=4): held beat discarded, scan restarts at port 0
        push(2, 2, 'h90);
        load(2, 2, 10, 'h90);
        step(2, tk);
        check("rst_burst_beat0", 32'(tk), 32'b0100);
        step(2, tk);
        check("rst_burst_beat1", 32'(tk), 32'b0100);
        check("rst_pre_valid", 32'(ovld[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(ovld[2]),     32'd0);
        check("rst_async_value", 32'(ov[23:16]),   32'd0);
        check("rst_async_port",  32'(op[5:4]),     32'd0);
        check("rst_async_ready", 32'(irdy[11:8]),  32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_in_ready", 32'(irdy[11:8]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load(2, 2, 4, 'h92);
        load(2, 3, 1, 'hA0);
        push(2, 2, 'h92); push(2, 2, 'h93); push(2, 2, 'h94);
        push(2, 2, 'h95); push(2, 3, 'hA0);
        for (int k = 0; k < 4; k++) begin
            step(2, tk);
            check("rst_restart_grant", 32'(tk), 32'b0100);
        end
        step(2, tk);
        check("rst_rotate_grant", 32'(tk), 32'b1000);
        step(2, tk);
        step(2, tk);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
